seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-cathode seven-segment digits that share one hex-to-segment decoder (`segment`). It stores one 4-bit value per digit and cycles the digit enables with a programmable dwell and a blanking gap between digits. It drives the shared decoder's nibble input and supports optional leading-zero suppression. It sits between the register/write side of the design and the display pins.

## Interface
- `NDIG`, 4: number of digits, 2..8.
- `DWELL`, 8: clock cycles each digit is lit, ≥2.
- `GAP`, 1: dead cycles between digits with all enables off, ≥1.

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable.
- `wr_en`  in  1  digit-store write strobe.
- `wr_addr`  in  3  digit index to write; 0 is the least significant digit.
- `wr_data`  in  4  nibble to store.
- `lz_sup`  in  1  leading-zero suppression enable.
- `nib`  out  4  nibble to the shared decoder input `a`.
- `dig_sel`  out  NDIG  one-hot digit enable, active-high.
- `blank`  out  1  high when no digit is lit.
- `frame`  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Digit store: NDIG×4 registers, all 0 on reset.
  - A write occurs when `wr_en`=1 and `wr_addr`<NDIG.
  - Writes with `wr_addr`≥NDIG are ignored.
  - A write is visible on the next SHOW entry for that index, never mid-dwell.
- FSM states:
  - OFF (reset state): `dig_sel`=0, `blank`=1, `nib`=0, `frame`=0, index=0, counter=0.
    - `en`=1 → SHOW(index 0).
  - SHOW: on entry, latch `store[idx]` into `nib` and evaluate suppression. Then hold for DWELL cycles:
    - not suppressed: `dig_sel`=one-hot(idx), `blank`=0.
    - suppressed: `dig_sel`=0, `blank`=1.
    - After DWELL cycles → GAP.
  - GAP: GAP cycles with `dig_sel`=0 and `blank`=1; `nib` holds its value.
    - On exit, idx increments modulo NDIG (NDIG-1 wraps to 0) → SHOW.
- `frame`=1 during the last GAP cycle of idx NDIG-1 only.
- `en`=0 in any state → OFF on the next edge; idx and counter clear. Re-enabling always restarts at digit 0.
- Leading-zero suppression, when `lz_sup`=1:
  - Digit i>0 is suppressed if `store[i]`=0 and `store[j]`=0 for every j>i.
  - Digit 0 is never suppressed.
  - Suppression is sampled at SHOW entry only.
- Simultaneous events:
  - A write to the index being entered on the same edge is not seen; the old value is latched.
  - A write to any other index is stored normally.
  - Writes are accepted in every state, including OFF.
- Reset mid-scan: all outputs go to their OFF values immediately (asynchronous). The digit store clears.
- All outputs are registered; none is a combinational function of an input.

## Timing
- `en` first sampled 1 at edge k → state SHOW(0), `dig_sel`=0001, `blank`=0 from edge k through edge k+DWELL.
- Per-digit period is DWELL+GAP cycles; full frame is NDIG·(DWELL+GAP) cycles. Defaults give 36.
- `dig_sel` is never multi-hot. At least GAP cycles of all-zero `dig_sel` separate two lit digits.
- `nib` changes only on the edge entering SHOW, never while any `dig_sel` bit is 1.
- `en` falling at edge m → OFF outputs from edge m.
- Write latency: `wr_en` at edge w updates the store at w. The value appears on `nib` at the next SHOW entry for that index that is strictly after w.

## Test plan
- Reset/idle: hold `rst_n`=0, then release with `en`=0 → `dig_sel`=0, `blank`=1, `nib`=0, `frame`=0 indefinitely.
- Basic scan, defaults: write 3,2,1,0 ← 4'h1,4'h2,4'hA,4'hF, then set `en`=1.
  - `nib` sequence per dwell is F,A,2,1 with `dig_sel` 0001,0010,0100,1000.
  - Each digit is lit 8 cycles with a 1-cycle gap.
  - `frame` pulses every 36 cycles.
  - Checker asserts `dig_sel` is never multi-hot.
- Leading-zero suppression: store {0,0,0,5} (digit 3..0), `lz_sup`=1.
  - Digits 3,2,1 stay blank for their dwell; only digit 0 lights, with `nib`=5.
  - Store {0,7,0,5} → only digit 3 is blanked; digit 1 lights with 0.
- Mid-dwell write: during SHOW(2), write `wr_addr`=2, `wr_data`=9.
  - `nib` is unchanged for the rest of that dwell.
  - `nib`=9 on the next SHOW(2), one frame later.
  - Write with `wr_addr`=6 (NDIG=4) → no store change.
- Disable and async reset: drop `en` during GAP(1) → OFF next edge; re-enable → restart at digit 0. Pulse `rst_n`=0 mid-SHOW → outputs go to OFF values before the next clock edge, and the store reads back 0.
- Parameter corner: NDIG=2, DWELL=2, GAP=1 → 6-cycle frame, idx wraps 1→0, `frame` on cycle 6.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a bank of multiplexed seven-segment digits sharing one decoder.
// Cycles digit enables with a programmable dwell, blanking gap and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DWELL = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic [3:0]      wr_data,
  input  logic            lz_sup,
  output logic [3:0]      nib,
  output logic [NDIG-1:0] dig_sel,
  output logic            blank,
  output logic            frame
);

  localparam int unsigned IdxW   = $clog2(NDIG);
  localparam int unsigned CntMax = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef enum logic [1:0] {StOff, StShow, StGap} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      nib_d;
  logic [NDIG-1:0] dig_sel_d;
  logic            blank_d;
  logic            frame_d;
  logic            last_idx;
  logic            suppress;
  logic [3:0]      store_q [NDIG];
  logic [NDIG-1:0] zero_above;

  // zero_above[i] is set when digit i and every more significant digit hold zero
  always_comb begin
    zero_above = '0;
    zero_above[NDIG-1] = (store_q[NDIG-1] == 4'h0);
    for (int i = int'(NDIG) - 2; i >= 0; i--) begin
      zero_above[i] = (store_q[i] == 4'h0) && zero_above[i+1];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    nib_d     = nib;
    dig_sel_d = '0;
    blank_d   = 1'b1;
    frame_d   = 1'b0;
    suppress  = 1'b0;
    last_idx  = (idx_q == IdxW'(NDIG - 1));

    unique case (state_q)
      StOff: begin
        if (en) begin
          state_d = StShow;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      StShow: begin
        if (cnt_q == CntW'(DWELL - 1)) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP - 1)) begin
          state_d = StShow;
          cnt_d   = '0;
          idx_d   = last_idx ? '0 : idx_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StOff;
    endcase

    if (!en) begin
      state_d = StOff;
      idx_d   = '0;
      cnt_d   = '0;
    end

    // Outputs are registered, so they are derived from the next state
    unique case (state_d)
      StOff: nib_d = 4'h0;
      StShow: begin
        if (state_q != StShow) begin
          // Entry: store_q is the pre-edge value, so a same-edge write is not seen
          nib_d    = store_q[idx_d];
          suppress = lz_sup && (idx_d != '0) && zero_above[idx_d];
          if (!suppress) begin
            dig_sel_d[idx_d] = 1'b1;
            blank_d          = 1'b0;
          end
        end else begin
          dig_sel_d = dig_sel;
          blank_d   = blank;
        end
      end
      StGap: begin
        frame_d = (idx_d == IdxW'(NDIG - 1)) && (cnt_d == CntW'(GAP - 1));
      end
      default: nib_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      idx_q   <= '0;
      cnt_q   <= '0;
      nib     <= 4'h0;
      dig_sel <= '0;
      blank   <= 1'b1;
      frame   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nib     <= nib_d;
      dig_sel <= dig_sel_d;
      blank   <= blank_d;
      frame   <= frame_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NDIG); i++) store_q[i] <= 4'h0;
    end else begin
      for (int i = 0; i < int'(NDIG); i++) begin
        if (wr_en && (wr_addr == 3'(i))) store_q[i] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: default 4-digit instance plus a 2-digit corner instance.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       en2;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       lz_sup;
  logic [3:0] nib, nib2;
  logic [3:0] dig_sel;
  logic [1:0] dig_sel2;
  logic       blank, blank2;
  logic       frame, frame2;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(.NDIG(4), .DWELL(8), .GAP(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .lz_sup  (lz_sup),
    .nib     (nib),
    .dig_sel (dig_sel),
    .blank   (blank),
    .frame   (frame)
  );

  seg_scan_ctrl #(.NDIG(2), .DWELL(2), .GAP(1)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en2),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .lz_sup  (lz_sup),
    .nib     (nib2),
    .dig_sel (dig_sel2),
    .blank   (blank2),
    .frame   (frame2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit enables must never be multi-hot
  always @(negedge clk) begin
    n_checks++;
    assert ($onehot0(dig_sel) === 1'b1) else begin
      n_fail++;
      $error("FAIL onehot: dig_sel=%b required at most one bit set", dig_sel);
    end
    n_checks++;
    assert ($onehot0(dig_sel2) === 1'b1) else begin
      n_fail++;
      $error("FAIL onehot2: dig_sel2=%b required at most one bit set", dig_sel2);
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_dig"}, 8'(dig_sel), 8'h0);
    chk({tag, "_blank"}, 8'(blank), 8'h1);
    chk({tag, "_nib"}, 8'(nib), 8'h0);
    chk({tag, "_frame"}, 8'(frame), 8'h0);
  endtask

  // Called at the sample right after SHOW(idx) entry; walks dwell plus gap.
  task automatic show_digit(input int idx, input logic [3:0] n, input bit lit,
                            input int wr_at, input logic [2:0] wa, input logic [3:0] wd,
                            input bit drop_en);
    logic [7:0] exp_dig;
    bit gap;
    for (int c = 0; c <= 8; c++) begin
      gap     = (c == 8);
      exp_dig = (lit && !gap) ? (8'h1 << idx) : 8'h0;
      chk($sformatf("d%0d_c%0d_dig", idx, c), 8'(dig_sel), exp_dig);
      chk($sformatf("d%0d_c%0d_blank", idx, c), 8'(blank), 8'(gap || !lit));
      chk($sformatf("d%0d_c%0d_nib", idx, c), 8'(nib), 8'(n));
      chk($sformatf("d%0d_c%0d_frame", idx, c), 8'(frame), 8'(gap && idx == 3));
      if (c == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = wa;
        wr_data = wd;
      end
      if (gap && drop_en) en = 1'b0;
      step();
      wr_en = 1'b0;
    end
  endtask

  logic [1:0] exp_dig2 [7];
  logic       exp_frm2 [7];

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    en2     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 4'h0;
    lz_sup  = 1'b0;
    repeat (2) step();
    chk_off("rst");
    rst_n = 1'b1;
    repeat (3) step();
    chk_off("idle");

    // Store 3..0 = 1,2,A,F; address 6 is out of range and must not alias digit 2
    wr(3'd3, 4'h1);
    wr(3'd2, 4'h2);
    wr(3'd1, 4'hA);
    wr(3'd0, 4'hF);
    wr(3'd6, 4'hC);
    chk_off("idle_wr");

    en = 1'b1;
    step();
    show_digit(0, 4'hF, 1, -1, 3'd0, 4'h0, 0);
    show_digit(1, 4'hA, 1, -1, 3'd0, 4'h0, 0);
    show_digit(2, 4'h2, 1, -1, 3'd0, 4'h0, 0);
    show_digit(3, 4'h1, 1, -1, 3'd0, 4'h0, 0);
    // Second frame: mid-dwell write to digit 2 must not change nib
    show_digit(0, 4'hF, 1, -1, 3'd0, 4'h0, 0);
    show_digit(1, 4'hA, 1, -1, 3'd0, 4'h0, 0);
    show_digit(2, 4'h2, 1, 3, 3'd2, 4'h9, 0);
    show_digit(3, 4'h1, 1, -1, 3'd0, 4'h0, 0);
    show_digit(0, 4'hF, 1, -1, 3'd0, 4'h0, 0);
    show_digit(1, 4'hA, 1, -1, 3'd0, 4'h0, 0);
    show_digit(2, 4'h9, 1, -1, 3'd0, 4'h0, 0);
    show_digit(3, 4'h1, 1, -1, 3'd0, 4'h0, 0);
    // Drop en during GAP(1)
    show_digit(0, 4'hF, 1, -1, 3'd0, 4'h0, 0);
    show_digit(1, 4'hA, 1, -1, 3'd0, 4'h0, 1);
    chk_off("dis");
    step();
    chk_off("dis2");

    // Leading-zero suppression with store {0,0,0,5}
    wr(3'd1, 4'h0);
    wr(3'd2, 4'h0);
    wr(3'd3, 4'h0);
    wr(3'd0, 4'h5);
    lz_sup = 1'b1;
    en     = 1'b1;
    step();
    show_digit(0, 4'h5, 1, -1, 3'd0, 4'h0, 0);
    show_digit(1, 4'h0, 0, -1, 3'd0, 4'h0, 0);
    show_digit(2, 4'h0, 0, -1, 3'd0, 4'h0, 0);
    show_digit(3, 4'h0, 0, -1, 3'd0, 4'h0, 0);
    // Store {0,7,0,5}: only digit 3 blanked
    show_digit(0, 4'h5, 1, 0, 3'd2, 4'h7, 0);
    show_digit(1, 4'h0, 1, -1, 3'd0, 4'h0, 0);
    show_digit(2, 4'h7, 1, -1, 3'd0, 4'h0, 0);
    show_digit(3, 4'h0, 0, -1, 3'd0, 4'h0, 0);
    // Write to digit 1 on the very edge that enters SHOW(1): old value latched
    show_digit(0, 4'h5, 1, 8, 3'd1, 4'h3, 0);
    show_digit(1, 4'h0, 1, -1, 3'd0, 4'h0, 0);
    show_digit(2, 4'h7, 1, -1, 3'd0, 4'h0, 0);
    show_digit(3, 4'h0, 0, -1, 3'd0, 4'h0, 0);
    show_digit(0, 4'h5, 1, -1, 3'd0, 4'h0, 0);
    show_digit(1, 4'h3, 1, -1, 3'd0, 4'h0, 0);

    // Async reset mid-SHOW(2)
    repeat (3) step();
    chk(8'(dig_sel) == 8'h4 ? "pre_rst_dig" : "pre_rst_dig", 8'(dig_sel), 8'h4);
    rst_n = 1'b0;
    #1;
    chk_off("arst");
    #1;
    rst_n  = 1'b1;
    lz_sup = 1'b0;
    step();
    // Store must be cleared: every digit lights with zero
    show_digit(0, 4'h0, 1, -1, 3'd0, 4'h0, 0);
    show_digit(1, 4'h0, 1, -1, 3'd0, 4'h0, 0);
    show_digit(2, 4'h0, 1, -1, 3'd0, 4'h0, 0);
    show_digit(3, 4'h0, 1, -1, 3'd0, 4'h0, 0);

    // Corner instance: NDIG=2, DWELL=2, GAP=1 gives a 6-cycle frame
    chk("c2_idle_dig", 8'(dig_sel2), 8'h0);
    chk("c2_idle_blank", 8'(blank2), 8'h1);
    exp_dig2 = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
    exp_frm2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en2 = 1'b1;
    step();
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("c2_%0d_dig", c), 8'(dig_sel2), 8'(exp_dig2[c]));
      chk($sformatf("c2_%0d_blank", c), 8'(blank2), 8'(exp_dig2[c] == 2'b00));
      chk($sformatf("c2_%0d_frame", c), 8'(frame2), 8'(exp_frm2[c]));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
